// File: rtl/scr_pkg.sv
// Shared types and defaults for the scratch-RAM stack controller.
package scr_pkg;

    localparam int SCR_ADDR_W = 8;
    localparam int SCR_DATA_W = 10;

    typedef logic [1:0] flags_t;  // {C,Z}

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SAVE_FLG = 2'd1,
        REST_PC  = 2'd2
    } state_t;

endpackage

// File: rtl/scr_stack_ctrl.sv
// Downward-growing stack controller over an external async-read scratch RAM,
// with a two-word context save (PC, flags) and matching restore sequence.
module scr_stack_ctrl
    import scr_pkg::*;
#(
    parameter int ADDR_W = SCR_ADDR_W,
    parameter int DATA_W = SCR_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PUSH,
    input  logic              POP,
    input  logic [DATA_W-1:0] PUSH_DATA,
    output logic [DATA_W-1:0] POP_DATA,
    input  logic              CTX_SAVE,
    input  logic              CTX_RESTORE,
    input  logic [DATA_W-1:0] CTX_PC,
    input  flags_t            CTX_FLAGS,
    output logic [DATA_W-1:0] RST_PC,
    output flags_t            RST_FLAGS,
    output logic              RST_VALID,
    output logic [ADDR_W-1:0] SP,
    output logic [ADDR_W:0]   COUNT,
    output logic              FULL,
    output logic              EMPTY,
    output logic              BUSY,
    output logic              OVF_ERR,
    output logic              UNF_ERR,
    input  logic              ERR_CLR,
    output logic [ADDR_W-1:0] SCR_ADDR,
    output logic [DATA_W-1:0] SCR_DIN,
    output logic              SCR_WE,
    input  logic [DATA_W-1:0] SCR_DOUT
);

    localparam logic [ADDR_W:0]   DEPTH_CNT  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_TWO    = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0]   SAVE_LIMIT = DEPTH_CNT - CNT_TWO;
    localparam logic [ADDR_W-1:0] SP_ONE     = ADDR_W'(1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] sp_reg, sp_next;
    logic [ADDR_W:0]   count_reg, count_next;
    flags_t            flags_reg, flags_next;
    logic              ovf_reg, ovf_next;
    logic              unf_reg, unf_next;

    logic              ovf_set, unf_set;
    logic [ADDR_W-1:0] sp_dec, sp_inc;
    logic              full_c, empty_c;
    logic [ADDR_W-1:0] scr_addr_c;
    logic [DATA_W-1:0] scr_din_c;
    logic              scr_we_c;
    logic [DATA_W-1:0] pop_data_c;
    logic              rst_valid_c;
    logic [DATA_W-1:0] rst_pc_c;
    flags_t            rst_flags_c;

    assign sp_dec  = sp_reg - SP_ONE;
    assign sp_inc  = sp_reg + SP_ONE;
    assign full_c  = (count_reg == DEPTH_CNT);
    assign empty_c = (count_reg == '0);

    always_comb begin
        state_next  = state_reg;
        sp_next     = sp_reg;
        count_next  = count_reg;
        flags_next  = flags_reg;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        scr_addr_c  = sp_reg;
        scr_din_c   = '0;
        scr_we_c    = 1'b0;
        pop_data_c  = '0;
        rst_valid_c = 1'b0;
        rst_pc_c    = '0;
        rst_flags_c = '0;

        unique case (state_reg)
            IDLE: begin
                if (CTX_SAVE) begin
                    // Both context words must fit before anything is written.
                    if (count_reg > SAVE_LIMIT) begin
                        ovf_set = 1'b1;
                    end else begin
                        scr_addr_c = sp_dec;
                        scr_din_c  = CTX_PC;
                        scr_we_c   = 1'b1;
                        sp_next    = sp_dec;
                        count_next = count_reg + CNT_ONE;
                        flags_next = CTX_FLAGS;
                        state_next = SAVE_FLG;
                    end
                end else if (CTX_RESTORE) begin
                    if (count_reg < CNT_TWO) begin
                        unf_set = 1'b1;
                    end else begin
                        scr_addr_c = sp_reg;
                        flags_next = flags_t'(SCR_DOUT[1:0]);
                        sp_next    = sp_inc;
                        count_next = count_reg - CNT_ONE;
                        state_next = REST_PC;
                    end
                end else if (PUSH) begin
                    if (full_c) begin
                        ovf_set = 1'b1;
                    end else begin
                        scr_addr_c = sp_dec;
                        scr_din_c  = PUSH_DATA;
                        scr_we_c   = 1'b1;
                        sp_next    = sp_dec;
                        count_next = count_reg + CNT_ONE;
                    end
                end else if (POP) begin
                    if (empty_c) begin
                        unf_set = 1'b1;
                    end else begin
                        scr_addr_c = sp_reg;
                        pop_data_c = SCR_DOUT;
                        sp_next    = sp_inc;
                        count_next = count_reg - CNT_ONE;
                    end
                end
            end
            SAVE_FLG: begin
                scr_addr_c = sp_dec;
                scr_din_c  = {{(DATA_W-2){1'b0}}, flags_reg};
                scr_we_c   = 1'b1;
                sp_next    = sp_dec;
                count_next = count_reg + CNT_ONE;
                state_next = IDLE;
            end
            REST_PC: begin
                scr_addr_c  = sp_reg;
                rst_valid_c = 1'b1;
                rst_pc_c    = SCR_DOUT;
                rst_flags_c = flags_reg;
                sp_next     = sp_inc;
                count_next  = count_reg - CNT_ONE;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A new error event outranks a clear arriving in the same cycle.
        ovf_next = ovf_set | (ovf_reg & ~ERR_CLR);
        unf_next = unf_set | (unf_reg & ~ERR_CLR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            sp_reg    <= '0;
            count_reg <= '0;
            flags_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sp_reg    <= sp_next;
            count_reg <= count_next;
            flags_reg <= flags_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    // Write enable is masked by reset so a held request cannot write during reset.
    assign SCR_WE    = scr_we_c & ~RST;
    assign SCR_ADDR  = scr_addr_c;
    assign SCR_DIN   = scr_din_c;
    assign POP_DATA  = pop_data_c;
    assign RST_VALID = rst_valid_c;
    assign RST_PC    = rst_pc_c;
    assign RST_FLAGS = rst_flags_c;
    assign SP        = sp_reg;
    assign COUNT     = count_reg;
    assign FULL      = full_c;
    assign EMPTY     = empty_c;
    assign BUSY      = (state_reg != IDLE);
    assign OVF_ERR   = ovf_reg;
    assign UNF_ERR   = unf_reg;

endmodule

// File: tb/tb_scr_stack_ctrl.sv
// Directed bench for scr_stack_ctrl with a behavioural async-read scratch RAM.
module tb_scr_stack_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PUSH = 1'b0, POP = 1'b0;
    logic [9:0] PUSH_DATA = '0;
    logic [9:0] POP_DATA;
    logic       CTX_SAVE = 1'b0, CTX_RESTORE = 1'b0;
    logic [9:0] CTX_PC = '0;
    logic [1:0] CTX_FLAGS = '0;
    logic [9:0] RST_PC;
    logic [1:0] RST_FLAGS;
    logic       RST_VALID;
    logic [7:0] SP;
    logic [8:0] COUNT;
    logic       FULL, EMPTY, BUSY, OVF_ERR, UNF_ERR;
    logic       ERR_CLR = 1'b0;
    logic [7:0] SCR_ADDR;
    logic [9:0] SCR_DIN;
    logic       SCR_WE;
    logic [9:0] SCR_DOUT;

    int total = 0;
    int bad   = 0;

    logic [9:0] mem [256];

    always #5 CLK = ~CLK;

    assign SCR_DOUT = mem[SCR_ADDR];
    always @(posedge CLK) if (SCR_WE) mem[SCR_ADDR] <= SCR_DIN;

    scr_stack_ctrl #(.ADDR_W(8), .DATA_W(10)) dut (
        .CLK(CLK), .RST(RST), .PUSH(PUSH), .POP(POP), .PUSH_DATA(PUSH_DATA),
        .POP_DATA(POP_DATA), .CTX_SAVE(CTX_SAVE), .CTX_RESTORE(CTX_RESTORE),
        .CTX_PC(CTX_PC), .CTX_FLAGS(CTX_FLAGS), .RST_PC(RST_PC),
        .RST_FLAGS(RST_FLAGS), .RST_VALID(RST_VALID), .SP(SP), .COUNT(COUNT),
        .FULL(FULL), .EMPTY(EMPTY), .BUSY(BUSY), .OVF_ERR(OVF_ERR),
        .UNF_ERR(UNF_ERR), .ERR_CLR(ERR_CLR), .SCR_ADDR(SCR_ADDR),
        .SCR_DIN(SCR_DIN), .SCR_WE(SCR_WE), .SCR_DOUT(SCR_DOUT)
    );

    task automatic idle_inputs();
        PUSH = 1'b0; POP = 1'b0; PUSH_DATA = '0;
        CTX_SAVE = 1'b0; CTX_RESTORE = 1'b0; CTX_PC = '0; CTX_FLAGS = '0;
        ERR_CLR = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle_inputs();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1; PUSH = 1'b1; PUSH_DATA = 10'h3FF;
        #1;
        total++; if (SCR_WE !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", SCR_WE); end
        total++; if (SP !== 8'h00) begin bad++; $display("FAIL rst_sp: got %h want 00", SP); end
        total++; if (COUNT !== 9'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", COUNT); end
        total++; if ({EMPTY, FULL, BUSY} !== 3'b100) begin bad++; $display("FAIL rst_flags3: got %b want 100", {EMPTY, FULL, BUSY}); end
        total++; if ({OVF_ERR, UNF_ERR, RST_VALID} !== 3'b000) begin bad++; $display("FAIL rst_err: got %b want 000", {OVF_ERR, UNF_ERR, RST_VALID}); end
        total++; if ({RST_PC, RST_FLAGS} !== 12'h000) begin bad++; $display("FAIL rst_ctx: got %h want 000", {RST_PC, RST_FLAGS}); end
        @(posedge CLK); #1;
        total++; if (COUNT !== 9'd0) begin bad++; $display("FAIL rst_hold_count: got %0d want 0", COUNT); end
        @(negedge CLK);
        idle_inputs();
        RST = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_push_pop();
        do_reset();
        @(negedge CLK); PUSH = 1'b1; PUSH_DATA = 10'h155; #1;
        total++; if ({SCR_WE, SCR_ADDR, SCR_DIN} !== {1'b1, 8'hFF, 10'h155}) begin bad++; $display("FAIL pp_w1: got we=%b a=%h d=%h want 1 ff 155", SCR_WE, SCR_ADDR, SCR_DIN); end
        @(posedge CLK); #1;
        total++; if (SP !== 8'hFF) begin bad++; $display("FAIL pp_sp1: got %h want ff", SP); end
        $display("push 155 at ff");
        @(negedge CLK); PUSH_DATA = 10'h2AA; #1;
        total++; if ({SCR_WE, SCR_ADDR, SCR_DIN} !== {1'b1, 8'hFE, 10'h2AA}) begin bad++; $display("FAIL pp_w2: got we=%b a=%h d=%h want 1 fe 2aa", SCR_WE, SCR_ADDR, SCR_DIN); end
        @(posedge CLK); #1;
        total++; if (COUNT !== 9'd2) begin bad++; $display("FAIL pp_cnt2: got %0d want 2", COUNT); end
        $display("push 2aa at fe");
        @(negedge CLK); PUSH = 1'b0; POP = 1'b1; #1;
        total++; if ({SCR_WE, POP_DATA} !== {1'b0, 10'h2AA}) begin bad++; $display("FAIL pp_pop1: got we=%b d=%h want 0 2aa", SCR_WE, POP_DATA); end
        @(posedge CLK); #1;
        total++; if (SP !== 8'hFF) begin bad++; $display("FAIL pp_sp3: got %h want ff", SP); end
        $display("pop 2aa");
        @(negedge CLK); #1;
        total++; if (POP_DATA !== 10'h155) begin bad++; $display("FAIL pp_pop2: got %h want 155", POP_DATA); end
        @(posedge CLK); #1;
        total++; if ({SP, EMPTY} !== {8'h00, 1'b1}) begin bad++; $display("FAIL pp_end: got sp=%h empty=%b want 00 1", SP, EMPTY); end
        $display("pop 155");
        @(negedge CLK); idle_inputs();
    endtask

    task automatic test_underflow();
        do_reset();
        @(negedge CLK); POP = 1'b1; #1;
        total++; if (POP_DATA !== 10'h000) begin bad++; $display("FAIL unf_data: got %h want 000", POP_DATA); end
        @(posedge CLK); #1;
        total++; if ({SP, UNF_ERR, OVF_ERR} !== {8'h00, 1'b1, 1'b0}) begin bad++; $display("FAIL unf_set: got sp=%h unf=%b ovf=%b want 00 1 0", SP, UNF_ERR, OVF_ERR); end
        $display("pop on empty");
        @(negedge CLK); ERR_CLR = 1'b1;
        @(posedge CLK); #1;
        total++; if (UNF_ERR !== 1'b1) begin bad++; $display("FAIL unf_win: got %b want 1", UNF_ERR); end
        @(negedge CLK); POP = 1'b0;
        @(posedge CLK); #1;
        total++; if (UNF_ERR !== 1'b0) begin bad++; $display("FAIL unf_clr: got %b want 0", UNF_ERR); end
        $display("underflow cleared");
        // One word only: a restore needs two.
        @(negedge CLK); ERR_CLR = 1'b0; PUSH = 1'b1; PUSH_DATA = 10'h0AA;
        @(negedge CLK); PUSH = 1'b0; CTX_RESTORE = 1'b1;
        @(posedge CLK); #1;
        total++; if ({SP, COUNT, BUSY, UNF_ERR} !== {8'hFF, 9'd1, 1'b0, 1'b1}) begin bad++; $display("FAIL unf_rest: got sp=%h cnt=%0d busy=%b unf=%b want ff 1 0 1", SP, COUNT, BUSY, UNF_ERR); end
        $display("restore with one word");
        @(negedge CLK); idle_inputs();
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 255; i++) begin
            @(negedge CLK); PUSH = 1'b1; PUSH_DATA = 10'(i);
        end
        @(negedge CLK); PUSH = 1'b0; CTX_SAVE = 1'b1; CTX_PC = 10'h123; #1;
        total++; if (SCR_WE !== 1'b0) begin bad++; $display("FAIL fill_save_we: got %b want 0", SCR_WE); end
        @(posedge CLK); #1;
        total++; if ({COUNT, OVF_ERR, BUSY} !== {9'd255, 1'b1, 1'b0}) begin bad++; $display("FAIL fill_save: got cnt=%0d ovf=%b busy=%b want 255 1 0", COUNT, OVF_ERR, BUSY); end
        $display("save at count 255 rejected");
        @(negedge CLK); CTX_SAVE = 1'b0; ERR_CLR = 1'b1;
        @(negedge CLK); ERR_CLR = 1'b0; PUSH = 1'b1; PUSH_DATA = 10'h0FF;
        @(posedge CLK); #1;
        total++; if ({FULL, SP, COUNT, OVF_ERR} !== {1'b1, 8'h00, 9'd256, 1'b0}) begin bad++; $display("FAIL fill_full: got full=%b sp=%h cnt=%0d ovf=%b want 1 00 256 0", FULL, SP, COUNT, OVF_ERR); end
        $display("filled 256 words");
        @(negedge CLK); PUSH_DATA = 10'h3FF; #1;
        total++; if (SCR_WE !== 1'b0) begin bad++; $display("FAIL ovf_we: got %b want 0", SCR_WE); end
        @(posedge CLK); #1;
        total++; if ({OVF_ERR, SP, COUNT} !== {1'b1, 8'h00, 9'd256}) begin bad++; $display("FAIL ovf_set: got ovf=%b sp=%h cnt=%0d want 1 00 256", OVF_ERR, SP, COUNT); end
        $display("push 257 rejected");
        @(negedge CLK); PUSH = 1'b0; ERR_CLR = 1'b1;
        @(posedge CLK); #1;
        total++; if (OVF_ERR !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", OVF_ERR); end
        @(negedge CLK); ERR_CLR = 1'b0; POP = 1'b1; #1;
        total++; if (POP_DATA !== 10'h0FF) begin bad++; $display("FAIL full_pop: got %h want 0ff", POP_DATA); end
        @(posedge CLK); #1;
        total++; if ({SP, FULL} !== {8'h01, 1'b0}) begin bad++; $display("FAIL full_pop_sp: got sp=%h full=%b want 01 0", SP, FULL); end
        $display("pop 0ff from full stack");
        @(negedge CLK); idle_inputs();
    endtask

    task automatic test_ctx_save_restore();
        do_reset();
        @(negedge CLK); CTX_SAVE = 1'b1; CTX_PC = 10'h3A5; CTX_FLAGS = 2'b10; #1;
        total++; if ({SCR_WE, SCR_ADDR, SCR_DIN} !== {1'b1, 8'hFF, 10'h3A5}) begin bad++; $display("FAIL sv_pc: got we=%b a=%h d=%h want 1 ff 3a5", SCR_WE, SCR_ADDR, SCR_DIN); end
        @(negedge CLK); CTX_SAVE = 1'b0; CTX_PC = 10'h111; CTX_FLAGS = 2'b01; #1;
        total++; if ({BUSY, SCR_WE, SCR_ADDR, SCR_DIN} !== {1'b1, 1'b1, 8'hFE, 10'h002}) begin bad++; $display("FAIL sv_flg: got busy=%b we=%b a=%h d=%h want 1 1 fe 002", BUSY, SCR_WE, SCR_ADDR, SCR_DIN); end
        @(posedge CLK); #1;
        total++; if ({BUSY, SP, COUNT} !== {1'b0, 8'hFE, 9'd2}) begin bad++; $display("FAIL sv_end: got busy=%b sp=%h cnt=%0d want 0 fe 2", BUSY, SP, COUNT); end
        total++; if ({mem[8'hFF], mem[8'hFE]} !== {10'h3A5, 10'h002}) begin bad++; $display("FAIL sv_mem: got %h %h want 3a5 002", mem[8'hFF], mem[8'hFE]); end
        $display("context saved pc=3a5 flags=10");
        @(negedge CLK); CTX_RESTORE = 1'b1; #1;
        total++; if ({SCR_WE, RST_VALID} !== 2'b00) begin bad++; $display("FAIL rs_first: got we=%b v=%b want 0 0", SCR_WE, RST_VALID); end
        @(negedge CLK); CTX_RESTORE = 1'b0; #1;
        total++; if ({RST_VALID, RST_PC, RST_FLAGS, BUSY} !== {1'b1, 10'h3A5, 2'b10, 1'b1}) begin bad++; $display("FAIL rs_out: got v=%b pc=%h f=%b busy=%b want 1 3a5 10 1", RST_VALID, RST_PC, RST_FLAGS, BUSY); end
        @(posedge CLK); #1;
        total++; if ({RST_VALID, SP, COUNT, BUSY} !== {1'b0, 8'h00, 9'd0, 1'b0}) begin bad++; $display("FAIL rs_end: got v=%b sp=%h cnt=%0d busy=%b want 0 00 0 0", RST_VALID, SP, COUNT, BUSY); end
        $display("context restored");
        @(negedge CLK); idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge CLK); CTX_SAVE = 1'b1; PUSH = 1'b1; PUSH_DATA = 10'h111; CTX_PC = 10'h0AB; CTX_FLAGS = 2'b01; #1;
        total++; if ({SCR_ADDR, SCR_DIN} !== {8'hFF, 10'h0AB}) begin bad++; $display("FAIL b2b_pc: got a=%h d=%h want ff 0ab", SCR_ADDR, SCR_DIN); end
        @(negedge CLK); CTX_SAVE = 1'b0; PUSH_DATA = 10'h222; #1;
        total++; if ({SCR_ADDR, SCR_DIN} !== {8'hFE, 10'h001}) begin bad++; $display("FAIL b2b_flg: got a=%h d=%h want fe 001", SCR_ADDR, SCR_DIN); end
        @(negedge CLK); PUSH = 1'b0;
        @(posedge CLK); #1;
        total++; if ({COUNT, SP, OVF_ERR, UNF_ERR} !== {9'd2, 8'hFE, 1'b0, 1'b0}) begin bad++; $display("FAIL b2b_end: got cnt=%0d sp=%h ovf=%b unf=%b want 2 fe 0 0", COUNT, SP, OVF_ERR, UNF_ERR); end
        $display("save with competing pushes");
        @(negedge CLK); idle_inputs();
    endtask

    task automatic test_reset_mid_save();
        do_reset();
        @(negedge CLK); CTX_SAVE = 1'b1; CTX_PC = 10'h2C3; CTX_FLAGS = 2'b11;
        @(posedge CLK); #1;
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", BUSY); end
        CTX_SAVE = 1'b0;
        #1; RST = 1'b1; #1;
        total++; if ({BUSY, SCR_WE, COUNT, SP} !== {1'b0, 1'b0, 9'd0, 8'h00}) begin bad++; $display("FAIL mid_rst: got busy=%b we=%b cnt=%0d sp=%h want 0 0 0 00", BUSY, SCR_WE, COUNT, SP); end
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;
        total++; if ({COUNT, mem[8'hFF]} !== {9'd0, 10'h2C3}) begin bad++; $display("FAIL mid_after: got cnt=%0d mem=%h want 0 2c3", COUNT, mem[8'hFF]); end
        $display("reset during save");
        @(negedge CLK); idle_inputs();
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_push_pop();
                test_underflow();
                test_fill_overflow();
                test_ctx_save_restore();
                test_back_to_back();
                test_reset_mid_save();
            end
            begin
                #200000;
                total++; bad++;
                $display("FAIL timeout: got running want finished");
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
